// File: rtl/divider20_seq_if.sv
// rtl/divider20_seq_if.sv - request/result bundle for the 20/19-bit sequential divider
//
// Signals:
//   start      request, sampled by the divider only while idle
//   dividend   signed 20-bit numerator, captured on the accepting edge
//   divisor    signed 19-bit denominator, captured on the accepting edge
//   busy       divider working (accepting edge until completion)
//   done       single-cycle completion pulse
//   quotient   signed 20-bit result, truncated toward zero
//   remainder  signed 19-bit result, sign of the dividend
//   ovf        quotient overflow (-524288 / -1)
//   dbz        divide by zero
// Modports: master drives requests and observes results; slave is the divider.

interface divider20_seq_if;
    logic               start;
    logic signed [19:0] dividend;
    logic signed [18:0] divisor;
    logic               busy;
    logic               done;
    logic signed [19:0] quotient;
    logic signed [18:0] remainder;
    logic               ovf;
    logic               dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, ovf, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, ovf, dbz
    );
endinterface

// File: rtl/divider20_seq.sv
// rtl/divider20_seq.sv - sequential signed restoring divider, one quotient bit per clock
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   divider20_seq_if.slave (start/dividend/divisor in; busy/done/quotient/
//         remainder/ovf/dbz out)
// Build option:
//   DIV20_SAT_EN  when defined, the overflow quotient saturates to +524287;
//                 otherwise it wraps to -524288. ovf is raised in both builds.

module divider20_seq (
    input  logic              clk,
    input  logic              rst,
    divider20_seq_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [19:0] Q_MAX = 20'h7FFFF;
    localparam logic [19:0] Q_MIN = 20'h80000;
    localparam logic [4:0]  LAST_ITER = 5'd19;

    state_t      state;
    state_t      state_nxt;

    // num_sh starts as |dividend|; each RUN cycle shifts its MSB into the
    // partial remainder and shifts the new quotient bit in at the bottom, so
    // after 20 cycles it holds |quotient|.
    logic [19:0] num_sh;
    logic [18:0] den_mag;
    logic [19:0] prem;
    logic [4:0]  iter;
    logic        num_neg;
    logic        den_neg;
    logic        den_zero;

    logic        accept;
    logic [19:0] num_abs;
    logic [18:0] den_abs;
    logic [19:0] trial;
    logic [19:0] den_ext;
    logic        trial_ge;
    logic [19:0] trial_diff;

    logic        q_neg;
    logic        ovf_fix;
    logic [19:0] q_fix;
    logic [18:0] r_fix;

    assign accept = (state == S_IDLE) && bus.start;

    // Two's-complement magnitudes; -524288 maps to 20'h80000 and -262144 to
    // 19'h40000, both of which are correct as unsigned values.
    assign num_abs = bus.dividend[19] ? (~$unsigned(bus.dividend) + 20'd1)
                                      : $unsigned(bus.dividend);
    assign den_abs = bus.divisor[18]  ? (~$unsigned(bus.divisor) + 19'd1)
                                      : $unsigned(bus.divisor);

    // The partial remainder is always below |divisor| <= 262144, so dropping
    // its MSB on the shift loses nothing.
    assign trial      = {prem[18:0], num_sh[19]};
    assign den_ext    = {1'b0, den_mag};
    assign trial_ge   = (trial >= den_ext);
    assign trial_diff = trial - den_ext;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.divisor == 19'sd0) ? S_FIX : S_RUN;
                end
            end
            S_RUN: begin
                if (iter == LAST_ITER) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Sign fix-up and special cases, consumed on the FIX edge
    // ------------------------------------------------------------------
    always_comb begin
        q_neg   = num_neg ^ den_neg;
        // Only |quotient| = 524288 with a positive sign cannot be represented.
        ovf_fix = !den_zero && !q_neg && num_sh[19];
        q_fix   = q_neg ? (~num_sh + 20'd1) : num_sh;
        r_fix   = num_neg ? (~prem[18:0] + 19'd1) : prem[18:0];

        if (den_zero) begin
            q_fix = num_neg ? Q_MIN : Q_MAX;
            r_fix = 19'd0;
        end else if (ovf_fix) begin
`ifdef DIV20_SAT_EN
            q_fix = Q_MAX;
`else
            q_fix = Q_MIN;
`endif
            r_fix = 19'd0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_sh        <= 20'd0;
            den_mag       <= 19'd0;
            prem          <= 20'd0;
            iter          <= 5'd0;
            num_neg       <= 1'b0;
            den_neg       <= 1'b0;
            den_zero      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.quotient  <= 20'sd0;
            bus.remainder <= 19'sd0;
            bus.ovf       <= 1'b0;
            bus.dbz       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        num_sh   <= num_abs;
                        den_mag  <= den_abs;
                        num_neg  <= bus.dividend[19];
                        den_neg  <= bus.divisor[18];
                        den_zero <= (bus.divisor == 19'sd0);
                        prem     <= 20'd0;
                        iter     <= 5'd0;
                        bus.busy <= 1'b1;
                        bus.ovf  <= 1'b0;
                        bus.dbz  <= 1'b0;
                    end
                end
                S_RUN: begin
                    prem   <= trial_ge ? trial_diff : trial;
                    num_sh <= {num_sh[18:0], trial_ge};
                    iter   <= iter + 5'd1;
                end
                S_FIX: begin
                    bus.quotient  <= $signed(q_fix);
                    bus.remainder <= $signed(r_fix);
                    bus.ovf       <= ovf_fix;
                    bus.dbz       <= den_zero;
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: begin
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider20_seq.sv
// tb/tb_divider20_seq.sv - self-checking bench for divider20_seq against an arithmetic model

module tb_divider20_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    divider20_seq_if bus ();

    divider20_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Integer division in SV truncates toward zero and % follows the
    // dividend's sign, which is exactly the required result definition.
    task automatic model(input int n, input int d,
                         output int q, output int r, output int ov, output int dz);
        ov = 0;
        dz = 0;
        if (d == 0) begin
            dz = 1;
            q  = (n >= 0) ? 524287 : -524288;
            r  = 0;
        end else if (n == -524288 && d == -1) begin
            ov = 1;
`ifdef DIV20_SAT_EN
            q  = 524287;
`else
            q  = -524288;
`endif
            r  = 0;
        end else begin
            q = n / d;
            r = n % d;
        end
    endtask

    // Issue one division and check latency, results and the done pulse.
    // poke_at >= 0 pulses start with other operands at that cycle of the run.
    task automatic run_div(input int n, input int d, input int poke_at);
        int q_exp, r_exp, ov_exp, dz_exp, lat, cyc;
        logic signed [19:0] nv;
        logic signed [18:0] dv;
        int qo, ro;
        model(n, d, q_exp, r_exp, ov_exp, dz_exp);
        lat = (d == 0) ? 1 : 21;
        nv  = n[19:0];
        dv  = d[18:0];
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = nv;
        bus.divisor  = dv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check($sformatf("busy_after_accept %0d/%0d", n, d), int'(bus.busy), 1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (cyc == poke_at) begin
                bus.start    = 1'b1;
                bus.dividend = 20'sd1;
                bus.divisor  = 19'sd1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        qo = bus.quotient;
        ro = bus.remainder;
        check($sformatf("latency %0d/%0d", n, d), cyc, lat);
        check($sformatf("quotient %0d/%0d", n, d), qo, q_exp);
        check($sformatf("remainder %0d/%0d", n, d), ro, r_exp);
        check($sformatf("ovf %0d/%0d", n, d), int'(bus.ovf), ov_exp);
        check($sformatf("dbz %0d/%0d", n, d), int'(bus.dbz), dz_exp);
        check($sformatf("busy_at_done %0d/%0d", n, d), int'(bus.busy), 0);
        @(posedge clk);
        #1;
        check($sformatf("done_one_cycle %0d/%0d", n, d), int'(bus.done), 0);
        qo = bus.quotient;
        check($sformatf("quotient_held %0d/%0d", n, d), qo, q_exp);
    endtask

    initial begin
        logic signed [19:0] rn;
        logic signed [18:0] rd;
        int seen_done;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = 20'sd0;
        bus.divisor  = 19'sd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_quotient", int'(bus.quotient), 0);
        check("reset_remainder", int'(bus.remainder), 0);
        check("reset_ovf", int'(bus.ovf), 0);
        check("reset_dbz", int'(bus.dbz), 0);
        @(negedge clk);
        rst = 1'b0;

        run_div(100, 7, -1);
        run_div(-100, 7, -1);
        run_div(100, -7, -1);
        run_div(-100, -7, -1);
        run_div(-524288, -1, -1);
        run_div(5, 0, -1);
        run_div(-5, 0, -1);
        run_div(0, 0, -1);
        run_div(3, -262144, -1);
        run_div(524287, 1, -1);
        run_div(-524288, 262143, -1);
        run_div(-524288, 1, -1);
        run_div(0, -3, -1);
        run_div(100, 7, 5);

        for (int i = 0; i < 24; i++) begin
            rn = 20'($urandom);
            rd = 19'($urandom);
            if (i % 6 == 5) rd = 19'sd0;
            if (i % 8 == 3) rd = 19'($urandom_range(1, 15));
            run_div(int'(rn), int'(rd), -1);
        end

        // Reset in the middle of a run: no completion, outputs cleared.
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 20'sd1000;
        bus.divisor  = 19'sd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(bus.busy), 0);
        check("midrst_done", int'(bus.done), 0);
        check("midrst_quotient", int'(bus.quotient), 0);
        check("midrst_remainder", int'(bus.remainder), 0);
        check("midrst_ovf", int'(bus.ovf), 0);
        check("midrst_dbz", int'(bus.dbz), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) seen_done++;
        end
        check("midrst_no_done", seen_done, 0);
        run_div(9, 2, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/divider20_seq.md
# divider20_seq

Sequential signed divider for accumulated neuron sums. It takes a 20-bit signed dividend, such as a two-operand sum produced by the 19-bit adder stage, and a 19-bit signed divisor. It returns quotient and remainder using restoring shift-subtract, one bit per clock. It sits after the adder/accumulator path and is used for averaging and normalisation before activation.

## Interface
- No parameters. Widths are fixed: dividend 20 bits, divisor 19 bits, matching the adder output and input widths.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- dividend  input  signed[19:0]  captured on the accepting edge.
- divisor  input  signed[18:0]  captured on the accepting edge.
- busy  output  1  high from the accepting edge until done.
- done  output  1  single-cycle completion pulse.
- quotient  output  signed[19:0]  truncated toward zero; held until the next completion.
- remainder  output  signed[18:0]  sign follows the dividend; held until the next completion.
- ovf  output  1  quotient overflow flag; valid while done=1 and held afterwards.
- dbz  output  1  divide-by-zero flag; valid while done=1 and held afterwards.

## Operation
- States:
  - IDLE: busy=0. On start=1, capture magnitudes |dividend| (20-bit unsigned) and |divisor| (19-bit unsigned), plus both sign bits.
    - Divisor = 0: go to FIX.
    - Otherwise: go to RUN with iteration counter = 0.
  - RUN: 20 iterations, one per cycle. Each cycle:
    - Shift a partial remainder (20 bits) left, bringing in the next dividend MSB.
    - If partial remainder ≥ |divisor|, subtract it and set the quotient bit to 1; else set it to 0.
    - After iteration 19, go to FIX.
  - FIX (1 cycle): apply signs and register the outputs. Pulse done. Return to IDLE.
- Sign rules:
  - Quotient is negative iff the operand signs differ and the magnitude is non-zero.
  - Remainder takes the dividend's sign; zero remainder stays 0.
- Overflow: the only case is dividend = −524288 with divisor = −1 (magnitude 524288). ovf=1; the quotient value depends on the configuration below. remainder=0.
- Divide by zero: dbz=1, ovf=0, remainder=0. Quotient is 524287 if dividend ≥ 0, else −524288.
- Remainder magnitude is always < |divisor| ≤ 262144, so it always fits in 19 bits signed.
- ovf and dbz are cleared on every new acceptance.
- start while busy=1 is ignored; no queuing.
- Outputs change only in FIX.

## Timing
- Reset values: busy=0, done=0, quotient=0, remainder=0, ovf=0, dbz=0, state=IDLE.
- Acceptance edge is E0; busy=1 after E0.
- Normal latency: 20 RUN edges plus 1 FIX edge. Outputs are valid and done=1 after edge E21, for exactly one cycle. busy falls together with done's rise.
- Divide-by-zero latency: FIX at E1, so done=1 after E1.
- start held high continuously: the next request is accepted on the first edge in IDLE, i.e. the edge on which done is high. Back-to-back throughput is one division per 22 cycles.
- Reset mid-operation: returns to IDLE immediately. All outputs are forced to reset values and no done pulse is issued.
- start asserted together with reset deassertion is accepted on the first clean edge.

## Configuration
- DIV20_SAT_EN defined: on overflow, quotient saturates to +524287.
- DIV20_SAT_EN undefined: on overflow, quotient wraps to −524288.
- ovf=1 is asserted in both builds. All other behaviour is identical.

## Test plan
- 100 / 7 -> quotient=14, remainder=2, ovf=0, dbz=0; done exactly one cycle, 21 edges after acceptance.
- Signs: −100 / 7 -> −14, −2. 100 / −7 -> −14, 2. −100 / −7 -> 14, −2.
- −524288 / −1 -> ovf=1, remainder=0. quotient=524287 with DIV20_SAT_EN, −524288 without.
- Divide by zero, each with done 1 edge after acceptance:
  - 5 / 0 -> dbz=1, quotient=524287, remainder=0.
  - −5 / 0 -> quotient=−524288.
- Small magnitude and extremes:
  - 3 / −262144 -> quotient=0, remainder=3.
  - 524287 / 1 -> 524287, 0.
  - −524288 / 262143 -> −2, −2.
- Control:
  - Pulse start at cycle 5 of a RUN -> ignored; the first result is unchanged.
  - Assert rst during RUN -> no done, outputs 0. A following 9 / 2 -> 4, 1.
